serial_subtractor: RTL and testbench
====================================

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits (legal range 2..32).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL change on its rising edge only.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin one subtraction.
REQ-005 The block SHALL have port a, input, WIDTH bits: unsigned minuend, sampled only when start is accepted.
REQ-006 The block SHALL have port b, input, WIDTH bits: unsigned subtrahend, sampled only when start is accepted.
REQ-007 The block SHALL have port bin, input, 1 bit: borrow-in, sampled only when start is accepted.
REQ-008 The block SHALL have port busy, output, 1 bit: high while an operation is in progress.
REQ-009 The block SHALL have port done, output, 1 bit: a one-cycle pulse marking a valid result.
REQ-010 The block SHALL have port diff, output, WIDTH bits: the difference, registered.
REQ-011 The block SHALL have port bout, output, 1 bit: the borrow-out, registered.

Function
REQ-012 The result SHALL satisfy {bout,diff} = a - b - bin, modulo 2^(WIDTH+1); bout SHALL be 1 exactly when a < b + bin (unsigned).
REQ-013 The block SHALL compute one bit per clock, LSB first, through a single 1-bit full-subtractor cell: d = x^y^br; br_next = (~x&y) | (~x&br) | (y&br).
REQ-014 The FSM SHALL have exactly three states, IDLE, RUN and DONE, with IDLE as the reset state.
REQ-015 In IDLE, start=1 SHALL be accepted at that edge: a and b are loaded into shift registers, bin into the borrow flop, the bit counter is cleared to 0, and the state goes to RUN.
REQ-016 In RUN, each edge SHALL:
  - process the LSBs of the a and b shift registers;
  - shift the result bit into diff from the MSB end;
  - shift both operand registers right by one;
  - update the borrow flop and increment the counter.
REQ-017 After the WIDTH-th RUN edge, the state SHALL go to DONE and bout SHALL be loaded from the final borrow.
REQ-018 DONE SHALL last exactly one cycle, then return to IDLE unconditionally.
REQ-019 Latency: start accepted at edge k SHALL give done=1 in the cycle after edge k+WIDTH, i.e. WIDTH+1 cycles after acceptance.
REQ-020 busy SHALL be 1 exactly when the state is RUN; done SHALL be 1 exactly when the state is DONE.
REQ-021 start SHALL be ignored in RUN and in DONE; it SHALL NOT be queued, and a, b and bin SHALL NOT be resampled.
REQ-022 diff and bout SHALL hold the last completed result from DONE onward until the next accepted start.
REQ-023 diff and bout SHALL be undefined-for-use while busy=1; the bench SHALL NOT check them then.
REQ-024 Back-to-back operation: start=1 held continuously SHALL be accepted in every IDLE cycle, giving one result every WIDTH+2 cycles.
REQ-025 Counter width SHALL be clog2(WIDTH+1) bits; no counter wrap-around SHALL occur within one operation.

Reset
REQ-026 rst=1 at an edge SHALL force the state to IDLE and clear busy, done, diff, bout, the counter, the borrow flop and both shift registers to 0.
REQ-027 rst SHALL take priority over start and over any in-progress RUN; reset mid-operation SHALL abandon the operation without producing a done pulse.
REQ-028 The first start SHALL be accepted at the first edge with rst=0 and start=1.

Structure
REQ-029 The state enum (IDLE/RUN/DONE) and the default WIDTH constant SHALL live in a shared package, serial_arith_pkg.
REQ-030 The 1-bit full-subtractor cell SHALL be a separate sub-module, fs, with ports a, b, bin, d, bout; serial_subtractor SHALL instantiate it exactly once.

Verification (WIDTH=8)
REQ-031 a=0x05, b=0x03, bin=0 -> done 9 cycles after start; diff=0x02, bout=0.
REQ-032 a=0x03, b=0x05, bin=0 -> diff=0xFE, bout=1; a=0x00, b=0x00, bin=1 -> diff=0xFF, bout=1.
REQ-033 a=0xFF, b=0xFF, bin=0 -> diff=0x00, bout=0; a=0x80, b=0x01, bin=1 -> diff=0x7E, bout=0.
REQ-034 Pulse start with a=0x10, b=0x01, then pulse start with a=0x00, b=0x01 at cycle 3 -> single done; diff=0x0F, bout=0.
REQ-035 Assert rst at cycle 4 of a run -> next edge: busy=0, diff=0x00, no done; then a=0x20, b=0x10, bin=0 -> diff=0x10, bout=0.
REQ-036 Run all 2^17 (a,b,bin) combinations back-to-back -> every result matches a - b - bin; done spacing is exactly 10 cycles.

Source files
------------

// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks: default operand
// width and the controller state encoding.
package serial_arith_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_subtractor_fs.sv
// One-bit full subtractor: d = a - b - bin, with the borrow out of that bit.
module fs (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~a & bin) | (b & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: {bout,diff} = a - b - bin, one bit per clock, LSB
// first, through a single full-subtractor cell.
module serial_subtractor
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             br_q, br_d;
    logic             bout_q, bout_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cell_d;
    logic             cell_br;

    fs u_fs (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .bin  (br_q),
        .d    (cell_d),
        .bout (cell_br)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        diff_d  = diff_q;
        br_d    = br_q;
        bout_d  = bout_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    br_d    = bin;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                // Result bits enter at the MSB so the LSB lands at bit 0 after WIDTH shifts.
                diff_d = {cell_d, diff_q[WIDTH-1:1]};
                a_d    = a_q >> 1;
                b_d    = b_q >> 1;
                br_d   = cell_br;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    bout_d  = cell_br;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            diff_q  <= '0;
            br_q    <= 1'b0;
            bout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            diff_q  <= diff_d;
            br_q    <= br_d;
            bout_q  <= bout_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign diff = diff_q;
    assign bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8): directed vectors,
// start-ignore, mid-run reset and a randomized back-to-back stream.
module tb_serial_subtractor;

    localparam int W     = 8;
    localparam int NOPS  = 1500;
    localparam int SPACE = W + 2;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a_i;
    logic [W-1:0] b_i;
    logic         bin_i;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         bout;

    int n_checks;
    int n_errors;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a_i),
        .b     (b_i),
        .bin   (bin_i),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer subtraction; negative means a borrow out.
    function automatic logic [W:0] ref_sub(input logic [W-1:0] x, input logic [W-1:0] y, input logic bi);
        int r;
        logic [W:0] res;
        r   = int'(x) - int'(y) - int'(bi);
        res = {(r < 0) ? 1'b1 : 1'b0, W'(r)};
        return res;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Single operation from IDLE: checks latency, result and one-cycle done.
    task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic bi);
        logic [W:0] exp;
        int n;
        exp   = ref_sub(x, y, bi);
        start = 1'b1;
        a_i   = x;
        b_i   = y;
        bin_i = bi;
        tick();
        start = 1'b0;
        check("busy_after_start", busy, 1'b1);
        n = 0;
        while (!done && n < 20) begin
            tick();
            n++;
        end
        check("latency", n, W);
        check("diff", diff, exp[W-1:0]);
        check("bout", bout, exp[W]);
        $display("op a=%02h b=%02h bin=%0d -> diff=%02h bout=%0d (lat %0d)", x, y, bi, diff, bout, n);
        tick();
        check("done_one_cycle", done, 1'b0);
        check("idle_busy", busy, 1'b0);
        check("diff_hold", diff, exp[W-1:0]);
    endtask

    logic [W-1:0] ea [NOPS];
    logic [W-1:0] eb [NOPS];
    logic         ebi[NOPS];

    initial begin
        logic [W:0] exp;
        int ndone;
        logic [W-1:0] seen_diff;
        logic seen_bout;
        n_checks = 0;
        n_errors = 0;
        rst   = 1'b1;
        start = 1'b0;
        a_i   = '0;
        b_i   = '0;
        bin_i = 1'b0;
        tick();
        start = 1'b1;
        a_i   = 8'hAA;
        tick();
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_diff", diff, 8'h00);
        check("rst_bout", bout, 1'b0);
        start = 1'b0;
        rst   = 1'b0;

        do_op(8'h05, 8'h03, 1'b0);
        do_op(8'h03, 8'h05, 1'b0);
        do_op(8'h00, 8'h00, 1'b1);
        do_op(8'hFF, 8'hFF, 1'b0);
        do_op(8'h80, 8'h01, 1'b1);

        // A second start while running is neither queued nor resampled.
        start = 1'b1;
        a_i   = 8'h10;
        b_i   = 8'h01;
        bin_i = 1'b0;
        tick();
        start = 1'b0;
        tick();
        tick();
        start = 1'b1;
        a_i   = 8'h00;
        b_i   = 8'h01;
        tick();
        start = 1'b0;
        ndone = 0;
        seen_diff = '0;
        seen_bout = 1'b0;
        for (int i = 0; i < 25; i++) begin
            if (done) begin
                ndone++;
                seen_diff = diff;
                seen_bout = bout;
            end
            tick();
        end
        check("ignore_done_count", ndone, 1);
        check("ignore_diff", seen_diff, 8'h0F);
        check("ignore_bout", seen_bout, 1'b0);
        $display("op a=10 b=01 bin=0 with ignored start -> diff=%02h bout=%0d dones=%0d", seen_diff, seen_bout, ndone);

        // Reset in the middle of a run abandons it.
        start = 1'b1;
        a_i   = 8'h55;
        b_i   = 8'h22;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        check("midrst_busy", busy, 1'b0);
        check("midrst_done", done, 1'b0);
        check("midrst_diff", diff, 8'h00);
        check("midrst_bout", bout, 1'b0);
        rst = 1'b0;
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            if (done) ndone++;
            tick();
        end
        check("midrst_no_done", ndone, 0);
        $display("op a=55 b=22 aborted by reset, dones=%0d", ndone);
        do_op(8'h20, 8'h10, 1'b0);

        // Back-to-back stream, start held high; operands are only meaningful on
        // acceptance edges, junk is driven in between.
        start = 1'b1;
        for (int e = 0; e < NOPS * SPACE; e++) begin
            int op;
            int ph;
            op = e / SPACE;
            ph = e % SPACE;
            if (ph == 0) begin
                case (op)
                    0: begin a_i = 8'h00; b_i = 8'hFF; bin_i = 1'b1; end
                    1: begin a_i = 8'hFF; b_i = 8'h00; bin_i = 1'b1; end
                    2: begin a_i = 8'h00; b_i = 8'h00; bin_i = 1'b0; end
                    3: begin a_i = 8'hFF; b_i = 8'h00; bin_i = 1'b0; end
                    default: begin
                        a_i   = W'($urandom);
                        b_i   = W'($urandom);
                        bin_i = 1'($urandom);
                    end
                endcase
                ea[op]  = a_i;
                eb[op]  = b_i;
                ebi[op] = bin_i;
            end else begin
                a_i   = W'($urandom);
                b_i   = W'($urandom);
                bin_i = 1'($urandom);
            end
            tick();
            check("b2b_busy", busy, (ph < W) ? 1'b1 : 1'b0);
            check("b2b_done", done, (ph == W) ? 1'b1 : 1'b0);
            if (ph == W) begin
                exp = ref_sub(ea[op], eb[op], ebi[op]);
                check("b2b_diff", diff, exp[W-1:0]);
                check("b2b_bout", bout, exp[W]);
                $display("b2b %0d a=%02h b=%02h bin=%0d -> diff=%02h bout=%0d", op, ea[op], eb[op], ebi[op], diff, bout);
            end
        end
        start = 1'b0;
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
